// File: rtl/ibex_mprf_pkg.sv
// Shared types and widths for the MPRF descriptor sender and its output FIFO.
package ibex_mprf_pkg;

  localparam int unsigned MprfAddrWidth = 5;
  localparam int unsigned MprfDataWidth = 32;
  localparam int unsigned DescLenWidth  = 5;
  localparam int unsigned DescDestWidth = 10;

  typedef enum logic [1:0] {
    DESC_IDLE  = 2'd0,
    DESC_ISSUE = 2'd1,
    DESC_DRAIN = 2'd2
  } desc_state_e;

  // Register 0 is hardwired to zero, so a descriptor walk wraps from 31 back to 1.
  function automatic logic [MprfAddrWidth-1:0] mprf_next_addr(input logic [MprfAddrWidth-1:0] addr);
    if (addr == '1) begin
      return MprfAddrWidth'(1);
    end
    return addr + MprfAddrWidth'(1);
  endfunction

endpackage

// File: rtl/ibex_mprf_desc_fifo.sv
// Synchronous FIFO buffering descriptor words ahead of the NoC egress port.
module ibex_mprf_desc_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 43,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = PtrWidth + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [Width-1:0]    rdata_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                full;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign push_ok = push_i & (~full | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ibex_mprf_desc_sender.sv
// Walks a range of MPRF registers through read port A and streams the words to the NoC,
// tagging each with an incrementing destination and marking the final word.
module ibex_mprf_desc_sender
  import ibex_mprf_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned DestWidth = DescDestWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [MprfAddrWidth-1:0] cmd_start_addr_i,
  input  logic [DescLenWidth-1:0]  cmd_len_i,
  input  logic [DestWidth-1:0]     cmd_dest_i,
  output logic                     mprf_rd_en_o,
  output logic [MprfAddrWidth-1:0] mprf_addr_o,
  input  logic                     port_busy_i,
  input  logic [MprfDataWidth-1:0] mprf_rdata_i,
  output logic                     noc_valid_o,
  input  logic                     noc_ready_i,
  output logic [MprfDataWidth-1:0] noc_data_o,
  output logic [DestWidth-1:0]     noc_dest_o,
  output logic                     noc_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned EntryWidth = MprfDataWidth + DestWidth + 1;
  localparam int unsigned CntWidth   = $clog2(FifoDepth) + 1;

  desc_state_e              state_q, state_d;
  logic [MprfAddrWidth-1:0] addr_q, addr_d;
  logic [DescLenWidth-1:0]  issue_cnt_q, issue_cnt_d;
  logic [DestWidth-1:0]     dest_q, dest_d;
  logic                     inflight_q, inflight_d;
  logic [DestWidth-1:0]     inflight_dest_q, inflight_dest_d;
  logic                     inflight_last_q, inflight_last_d;
  logic                     done_q, done_d;

  logic [EntryWidth-1:0]    fifo_wdata;
  logic [EntryWidth-1:0]    fifo_rdata;
  logic                     fifo_empty;
  logic [CntWidth-1:0]      fifo_count;
  logic [CntWidth-1:0]      occupancy;
  logic                     credit;
  logic                     rd_accept;
  logic                     noc_pop;
  logic                     last_pop;

  // Reads in flight count against FIFO space so returning data always has a slot.
  assign occupancy = fifo_count + CntWidth'(inflight_q);
  assign credit    = (occupancy < CntWidth'(FifoDepth));

  assign mprf_rd_en_o = (state_q == DESC_ISSUE) && (issue_cnt_q != '0) && credit;
  assign mprf_addr_o  = addr_q;
  assign rd_accept    = mprf_rd_en_o & ~port_busy_i;

  assign cmd_ready_o = (state_q == DESC_IDLE);
  assign busy_o      = (state_q != DESC_IDLE);

  assign noc_valid_o = ~fifo_empty;
  assign noc_data_o  = fifo_empty ? '0 : fifo_rdata[EntryWidth-1 -: MprfDataWidth];
  assign noc_dest_o  = fifo_empty ? '0 : fifo_rdata[DestWidth:1];
  assign noc_last_o  = fifo_empty ? 1'b0 : fifo_rdata[0];
  assign noc_pop     = noc_valid_o & noc_ready_i;
  assign last_pop    = noc_pop & noc_last_o & (state_q == DESC_DRAIN);

  assign done_o = done_q | last_pop;

  assign fifo_wdata = {mprf_rdata_i, inflight_dest_q, inflight_last_q};

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    issue_cnt_d     = issue_cnt_q;
    dest_d          = dest_q;
    inflight_d      = 1'b0;
    inflight_dest_d = inflight_dest_q;
    inflight_last_d = inflight_last_q;
    done_d          = 1'b0;
    unique case (state_q)
      DESC_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i != '0) begin
            addr_d      = cmd_start_addr_i;
            issue_cnt_d = cmd_len_i;
            dest_d      = cmd_dest_i;
            state_d     = DESC_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DESC_ISSUE: begin
        if (rd_accept) begin
          addr_d          = mprf_next_addr(addr_q);
          issue_cnt_d     = issue_cnt_q - DescLenWidth'(1);
          dest_d          = dest_q + DestWidth'(1);
          inflight_d      = 1'b1;
          inflight_dest_d = dest_q;
          inflight_last_d = (issue_cnt_q == DescLenWidth'(1));
          if (issue_cnt_q == DescLenWidth'(1)) begin
            state_d = DESC_DRAIN;
          end
        end
      end
      DESC_DRAIN: begin
        if (last_pop) begin
          state_d = DESC_IDLE;
        end
      end
      default: state_d = DESC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= DESC_IDLE;
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      dest_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_dest_q <= '0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      issue_cnt_q     <= issue_cnt_d;
      dest_q          <= dest_d;
      inflight_q      <= inflight_d;
      inflight_dest_q <= inflight_dest_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  ibex_mprf_desc_fifo #(
    .Depth(FifoDepth),
    .Width(EntryWidth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (inflight_q),
    .wdata_i(fifo_wdata),
    .pop_i  (noc_ready_i),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule
